rd_check_fsm: RTL and testbench

Read-back checker that pairs with the write-side FSM. After a write phase fills a single-port RAM with an incrementing pattern, this block reads the same address range back. It compares each returned word against the expected value and reports any mismatch. It is the reader/verifier end of the RAM write/read-check loop, and drives the RAM read port directly.

---
 rtl/rd_check_fsm_pkg.sv | 18 +
 rtl/rd_check_cmp.sv | 80 ++++++++
 rtl/rd_check_fsm.sv | 117 +++++++++++
 tb/tb_rd_check_fsm.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/rd_check_fsm_pkg.sv
// Shared definitions for the RAM write/read-check loop: FSM state encoding
// and the data pattern both the writer and this reader agree on.
package rd_check_fsm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } rd_state_t;

  // Pattern word stored at address addr; callers truncate to the data width.
  function automatic logic [31:0] expected_word(input logic [31:0] addr,
                                                input logic [31:0] seed);
    return addr + seed;
  endfunction

endpackage

// File: rtl/rd_check_cmp.sv
// Registered compare stage of the read-back checker. Lines up the issued
// address with the RAM data one cycle later, checks it against the pattern
// and keeps the sticky flag, first failing address and saturating count.
module rd_check_cmp
  import rd_check_fsm_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16,
  parameter int SEED   = 0,
  parameter int ERRC_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              iss_vld,
  input  logic [ADDR_W-1:0] iss_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              error_flag,
  output logic [ADDR_W-1:0] err_addr,
  output logic [ERRC_W-1:0] err_cnt
);

  localparam logic [ERRC_W-1:0] ERR_MAX = {ERRC_W{1'b1}};

  logic              cmp_vld_r;
  logic [ADDR_W-1:0] cmp_addr_r;
  logic              error_flag_r;
  logic [ADDR_W-1:0] err_addr_r;
  logic [ERRC_W-1:0] err_cnt_r;
  logic [DATA_W-1:0] exp_s;
  logic              mismatch_s;

  // Expected word for the address whose data is on rd_data this cycle.
  always_comb begin
    exp_s      = DATA_W'(expected_word(32'(cmp_addr_r), 32'(SEED)));
    mismatch_s = 1'b0;
    if (cmp_vld_r) begin
      mismatch_s = (rd_data != exp_s);
    end else begin
      mismatch_s = 1'b0;
    end
  end

  // Delay the issued read by the RAM latency so address and data meet.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmp_vld_r  <= 1'b0;
      cmp_addr_r <= '0;
    end else begin
      cmp_vld_r  <= iss_vld;
      cmp_addr_r <= iss_addr;
    end
  end

  // Error bookkeeping: cleared on an accepted start, otherwise sticky.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      error_flag_r <= 1'b0;
      err_addr_r   <= '0;
      err_cnt_r    <= '0;
    end else if (clr) begin
      error_flag_r <= 1'b0;
      err_addr_r   <= '0;
      err_cnt_r    <= '0;
    end else if (mismatch_s) begin
      error_flag_r <= 1'b1;
      if (!error_flag_r) begin
        err_addr_r <= cmp_addr_r;
      end
      if (err_cnt_r != ERR_MAX) begin
        err_cnt_r <= err_cnt_r + ERRC_W'(1);
      end
    end
  end

  assign error_flag = error_flag_r;
  assign err_addr   = err_addr_r;
  assign err_cnt    = err_cnt_r;

endmodule

// File: rtl/rd_check_fsm.sv
// Read-back checker: sweeps addresses 0..NUM-1 through the RAM read port
// after a write pass and reports words that differ from the pattern.
module rd_check_fsm
  import rd_check_fsm_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16,
  parameter int NUM    = 1024,
  parameter int SEED   = 0,
  parameter int ERRC_W = 8
) (
  input  logic              sclk,
  input  logic              rst_n,
  input  logic              read_start,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic              error_flag,
  output logic [ADDR_W-1:0] err_addr,
  output logic [ERRC_W-1:0] err_cnt
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM - 1);

  rd_state_t         state_r;
  logic [ADDR_W-1:0] read_cnt_r;
  logic              rd_en_r;
  logic              busy_r;
  logic              done_r;
  logic              start_s;

  // A start pulse only counts while idle; during a pass it is ignored.
  always_comb begin
    start_s = 1'b0;
    if (state_r == ST_IDLE) begin
      start_s = read_start;
    end else begin
      start_s = 1'b0;
    end
  end

  // Pass sequencer: issue one read per cycle, drain the last compare, pulse done.
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      read_cnt_r <= '0;
      rd_en_r    <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (start_s) begin
            state_r    <= ST_READ;
            read_cnt_r <= '0;
            rd_en_r    <= 1'b1;
            busy_r     <= 1'b1;
          end else begin
            rd_en_r <= 1'b0;
            busy_r  <= 1'b0;
          end
        end
        ST_READ: begin
          if (read_cnt_r == LAST_ADDR) begin
            state_r <= ST_DRAIN;
            rd_en_r <= 1'b0;
          end else begin
            read_cnt_r <= read_cnt_r + ADDR_W'(1);
            rd_en_r    <= 1'b1;
          end
        end
        ST_DRAIN: begin
          state_r <= ST_DONE;
          done_r  <= 1'b1;
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r    <= ST_IDLE;
          read_cnt_r <= '0;
          rd_en_r    <= 1'b0;
          busy_r     <= 1'b0;
          done_r     <= 1'b0;
        end
      endcase
    end
  end

  assign rd_en   = rd_en_r;
  assign rd_addr = read_cnt_r;
  assign busy    = busy_r;
  assign done    = done_r;

  rd_check_cmp #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .SEED   (SEED),
    .ERRC_W (ERRC_W)
  ) u_cmp (
    .clk        (sclk),
    .rst_n      (rst_n),
    .clr        (start_s),
    .iss_vld    (rd_en_r),
    .iss_addr   (read_cnt_r),
    .rd_data    (rd_data),
    .error_flag (error_flag),
    .err_addr   (err_addr),
    .err_cnt    (err_cnt)
  );

endmodule

// File: tb/tb_rd_check_fsm.sv
// Bench for rd_check_fsm: three instances (NUM=1024, NUM=1, NUM=300) each
// reading a behavioural RAM. Per-pass expectations go into a scoreboard
// queue when the start pulse is driven and are checked at the done pulse.
module tb_rd_check_fsm;

  logic sclk = 1'b0;
  logic rst_n;
  always #5 sclk = ~sclk;

  logic        start_w      [3];
  logic        rd_en_w      [3];
  logic [9:0]  rd_addr_w    [3];
  logic [15:0] rd_data_w    [3];
  logic        busy_w       [3];
  logic        done_w       [3];
  logic        error_flag_w [3];
  logic [9:0]  err_addr_w   [3];
  logic [7:0]  err_cnt_w    [3];

  logic [15:0] ram [3][1024];
  int seed_tab [3] = '{0, 7, 5};

  int n_checks = 0;
  int n_fail   = 0;

  rd_check_fsm #(.NUM(1024), .SEED(0)) u_dut0 (
    .sclk(sclk), .rst_n(rst_n), .read_start(start_w[0]), .rd_en(rd_en_w[0]),
    .rd_addr(rd_addr_w[0]), .rd_data(rd_data_w[0]), .busy(busy_w[0]), .done(done_w[0]),
    .error_flag(error_flag_w[0]), .err_addr(err_addr_w[0]), .err_cnt(err_cnt_w[0]));

  rd_check_fsm #(.NUM(1), .SEED(7)) u_dut1 (
    .sclk(sclk), .rst_n(rst_n), .read_start(start_w[1]), .rd_en(rd_en_w[1]),
    .rd_addr(rd_addr_w[1]), .rd_data(rd_data_w[1]), .busy(busy_w[1]), .done(done_w[1]),
    .error_flag(error_flag_w[1]), .err_addr(err_addr_w[1]), .err_cnt(err_cnt_w[1]));

  rd_check_fsm #(.NUM(300), .SEED(5)) u_dut2 (
    .sclk(sclk), .rst_n(rst_n), .read_start(start_w[2]), .rd_en(rd_en_w[2]),
    .rd_addr(rd_addr_w[2]), .rd_data(rd_data_w[2]), .busy(busy_w[2]), .done(done_w[2]),
    .error_flag(error_flag_w[2]), .err_addr(err_addr_w[2]), .err_cnt(err_cnt_w[2]));

  // Single-port RAM models with one cycle of read latency.
  for (genvar g = 0; g < 3; g++) begin : g_ram
    always @(posedge sclk) begin
      if (rd_en_w[g]) rd_data_w[g] <= ram[g][rd_addr_w[g]];
    end
  end

  typedef struct {
    int          sel;
    int          c0;
    int          c1;
    bit          all_bad;
    int          force_cyc;
    int          restart_cyc;
    logic        exp_flag;
    logic [9:0]  exp_addr;
    logic [7:0]  exp_cnt;
    int          exp_lat;
  } vec_t;

  typedef struct {
    logic        flag;
    logic [9:0]  addr;
    logic [7:0]  cnt;
    int          lat;
  } exp_t;

  exp_t sb [$];
  vec_t vt [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic flag, input logic [9:0] addr, input logic [7:0] cnt,
                          input int lat);
    exp_t e;
    e.flag = flag; e.addr = addr; e.cnt = cnt; e.lat = lat;
    sb.push_back(e);
  endtask

  // Fill RAM sel with the pattern, flipping the MSB of chosen words.
  task automatic load_ram(input int sel, input int c0, input int c1, input bit all_bad);
    logic [15:0] w;
    for (int a = 0; a < 1024; a++) begin
      w = 16'(a + seed_tab[sel]);
      if (all_bad || a == c0 || a == c1) w = w ^ 16'h8000;
      ram[sel][a] = w;
    end
  endtask

  // Pulse start, run until done (bounded), then check against the scoreboard.
  task automatic do_pass(input int sel, input int force_cyc, input int restart_cyc);
    int   cyc;
    bit   seen;
    exp_t e;
    @(negedge sclk); start_w[sel] = 1'b1;
    @(negedge sclk); start_w[sel] = 1'b0;
    cyc  = 1;
    seen = 1'b0;
    while (!seen && cyc < 4000) begin
      if (done_w[sel]) begin
        seen = 1'b1;
      end else begin
        start_w[sel] = (cyc == restart_cyc);
        if (sel == 0 && cyc == force_cyc) begin
          force u_dut0.read_cnt_r = 10'd2;
          #1;
          release u_dut0.read_cnt_r;
        end
        @(negedge sclk);
        cyc++;
      end
    end
    start_w[sel] = 1'b0;
    if (sb.size() == 0) begin
      n_checks++; n_fail++;
      $display("FAIL scoreboard_empty: got a pass on dut %0d, expected a queued entry", sel);
      return;
    end
    e = sb.pop_front();
    if (!seen) begin
      n_checks++; n_fail++;
      $display("FAIL done_timeout: got no done in %0d cycles, expected done at %0d", cyc, e.lat);
    end else begin
      check("done_latency", cyc, e.lat);
      check("busy_at_done", busy_w[sel], 1'b1);
      check("error_flag", error_flag_w[sel], e.flag);
      check("err_addr", err_addr_w[sel], e.addr);
      check("err_cnt", err_cnt_w[sel], e.cnt);
      @(negedge sclk);
      check("done_single_pulse", done_w[sel], 1'b0);
      check("busy_after_done", busy_w[sel], 1'b0);
      check("error_flag_hold", error_flag_w[sel], e.flag);
      check("err_cnt_hold", err_cnt_w[sel], e.cnt);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1);
  end

  initial begin
    exp_t dummy;
    dummy.lat = 0;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) start_w[i] = 1'b0;

    // sel c0 c1 all force restart | flag addr cnt lat
    vt[0] = '{0, -1,   -1,  1'b0, -1, -1,  1'b0, 10'd0,    8'd0,   1026};
    vt[1] = '{0,  5,   700, 1'b0, -1, -1,  1'b1, 10'd5,    8'd2,   1026};
    vt[2] = '{0, -1,   -1,  1'b0, 11, -1,  1'b0, 10'd0,    8'd0,   1034};
    vt[3] = '{0,  5,   -1,  1'b0, -1, 100, 1'b1, 10'd5,    8'd1,   1026};
    vt[4] = '{0,  1023, -1, 1'b0, -1, -1,  1'b1, 10'd1023, 8'd1,   1026};
    vt[5] = '{2, -1,   -1,  1'b1, -1, -1,  1'b1, 10'd0,    8'd255, 302};
    vt[6] = '{2, -1,   -1,  1'b0, -1, -1,  1'b0, 10'd0,    8'd0,   302};

    #17;
    for (int i = 0; i < 3; i++) begin
      check("rst_rd_en", rd_en_w[i], 1'b0);
      check("rst_rd_addr", rd_addr_w[i], 10'd0);
      check("rst_busy", busy_w[i], 1'b0);
      check("rst_done", done_w[i], 1'b0);
      check("rst_error_flag", error_flag_w[i], 1'b0);
      check("rst_err_addr", err_addr_w[i], 10'd0);
      check("rst_err_cnt", err_cnt_w[i], 8'd0);
    end
    @(negedge sclk); rst_n = 1'b1;
    repeat (25) @(negedge sclk);

    for (int i = 0; i < 7; i++) begin
      load_ram(vt[i].sel, vt[i].c0, vt[i].c1, vt[i].all_bad);
      push_exp(vt[i].exp_flag, vt[i].exp_addr, vt[i].exp_cnt, vt[i].exp_lat);
      do_pass(vt[i].sel, vt[i].force_cyc, vt[i].restart_cyc);
    end

    // Reset in the middle of a pass, with an error already recorded.
    load_ram(0, 5, -1, 1'b0);
    @(negedge sclk); start_w[0] = 1'b1;
    @(negedge sclk); start_w[0] = 1'b0;
    repeat (500) @(negedge sclk);
    check("midpass_rd_addr", rd_addr_w[0], 10'd500);
    check("midpass_error_flag", error_flag_w[0], 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rd_en", rd_en_w[0], 1'b0);
    check("async_rd_addr", rd_addr_w[0], 10'd0);
    check("async_busy", busy_w[0], 1'b0);
    check("async_done", done_w[0], 1'b0);
    check("async_error_flag", error_flag_w[0], 1'b0);
    check("async_err_addr", err_addr_w[0], 10'd0);
    check("async_err_cnt", err_cnt_w[0], 8'd0);
    @(negedge sclk); @(negedge sclk); rst_n = 1'b1;
    repeat (3) @(negedge sclk);
    check("post_rst_done", done_w[0], 1'b0);
    check("post_rst_busy", busy_w[0], 1'b0);
    load_ram(0, -1, -1, 1'b0);
    push_exp(1'b0, 10'd0, 8'd0, 1026);
    do_pass(0, -1, -1);

    // Single-word passes with a bad word and a saturated counter preloaded.
    load_ram(1, 0, -1, 1'b0);
    for (int p = 0; p < 300; p++) begin
      @(negedge sclk);
      force u_dut1.u_cmp.err_cnt_r = 8'hFF;
      #1;
      release u_dut1.u_cmp.err_cnt_r;
      push_exp(1'b1, 10'd0, 8'd1, 3);
      do_pass(1, -1, -1);
    end

    check("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
